// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit CPU pipeline: data/register widths,
// writeback source encoding and the writeback-stage state encoding.
package cpu_pkg;

    localparam int DSIZE = 16;
    localparam int RSIZE = 4;

    typedef enum logic [2:0] {
        WB_NONE = 3'd0,
        WB_ALU  = 3'd1,
        WB_LOAD = 3'd2,
        WB_LHB  = 3'd3,
        WB_LLB  = 3'd4,
        WB_JAL  = 3'd5
    } wb_op_e;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_WAIT  = 2'd2
    } wb_state_e;

    // Encodings 6 and 7 are reserved and behave as NONE.
    function automatic wb_op_e wb_op_decode(input logic [2:0] raw);
        case (raw)
            3'd1:    return WB_ALU;
            3'd2:    return WB_LOAD;
            3'd3:    return WB_LHB;
            3'd4:    return WB_LLB;
            3'd5:    return WB_JAL;
            default: return WB_NONE;
        endcase
    endfunction

endpackage

// File: rtl/wb_mux.sv
// Writeback data merge: selects ALU result, byte-immediate merges into the
// old register value, or the JAL return address. Loads and NONE yield 0.
module wb_mux
    import cpu_pkg::*;
#(
    parameter int DSIZE = cpu_pkg::DSIZE
) (
    input  wb_op_e           op,
    input  logic [DSIZE-1:0] alu,
    input  logic [7:0]       imm,
    input  logic [DSIZE-1:0] old,
    input  logic [DSIZE-1:0] pc1,
    output logic [DSIZE-1:0] data
);

    always_comb begin
        data = '0;
        case (op)
            WB_ALU:  data = alu;
            WB_LHB:  data = {imm, old[DSIZE-9:0]};
            WB_LLB:  data = {old[DSIZE-1:8], imm};
            WB_JAL:  data = pc1;
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: single-entry holding register in front of the register
// file write port, with load-data stall and a bounded load timeout.
module wb_stage
    import cpu_pkg::*;
#(
    parameter int DSIZE   = cpu_pkg::DSIZE,
    parameter int RSIZE   = cpu_pkg::RSIZE,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [RSIZE-1:0] in_rd,
    input  logic [DSIZE-1:0] in_alu,
    input  logic [7:0]       in_imm,
    input  logic [DSIZE-1:0] in_old,
    input  logic [DSIZE-1:0] in_pc1,
    input  logic             mem_rvalid,
    input  logic [DSIZE-1:0] mem_rdata,
    output logic             rf_wen,
    output logic [RSIZE-1:0] rf_waddr,
    output logic [DSIZE-1:0] rf_wdata,
    output logic             busy,
    output logic [15:0]      retire_cnt,
    output logic             err
);

    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

    wb_state_e        state_reg, state_next;
    wb_op_e           op_reg, op_next;
    logic [RSIZE-1:0] rd_reg, rd_next;
    logic [DSIZE-1:0] data_reg, data_next;
    logic [15:0]      wait_cnt_reg, wait_cnt_next;
    logic [15:0]      retire_cnt_reg, retire_cnt_next;
    logic             err_reg, err_next;

    wb_op_e           in_op_dec;
    logic [DSIZE-1:0] merged_data;
    logic             completing;
    logic             retiring;
    logic             accept;
    logic             wen_raw;
    logic [DSIZE-1:0] wdata_raw;

    assign in_op_dec = wb_op_decode(in_op);

    wb_mux #(
        .DSIZE(DSIZE)
    ) u_wb_mux (
        .op   (in_op_dec),
        .alu  (in_alu),
        .imm  (in_imm),
        .old  (in_old),
        .pc1  (in_pc1),
        .data (merged_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_EMPTY;
            op_reg         <= WB_NONE;
            rd_reg         <= '0;
            data_reg       <= '0;
            wait_cnt_reg   <= '0;
            retire_cnt_reg <= '0;
            err_reg        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            op_reg         <= op_next;
            rd_reg         <= rd_next;
            data_reg       <= data_next;
            wait_cnt_reg   <= wait_cnt_next;
            retire_cnt_reg <= retire_cnt_next;
            err_reg        <= err_next;
        end
    end

    always_comb begin
        completing      = 1'b0;
        retiring        = 1'b0;
        wen_raw         = 1'b0;
        wdata_raw       = data_reg;
        state_next      = state_reg;
        op_next         = op_reg;
        rd_next         = rd_reg;
        data_next       = data_reg;
        wait_cnt_next   = wait_cnt_reg;
        retire_cnt_next = retire_cnt_reg;
        err_next        = err_reg;

        case (state_reg)
            ST_FULL: begin
                completing = 1'b1;
                retiring   = 1'b1;
                wen_raw    = (op_reg != WB_NONE) && (rd_reg != '0);
            end
            ST_WAIT: begin
                if (mem_rvalid) begin
                    completing = 1'b1;
                    retiring   = 1'b1;
                    wen_raw    = (rd_reg != '0);
                    wdata_raw  = mem_rdata;
                end else if (wait_cnt_reg == WAIT_LAST) begin
                    // Give up on the load: flag it and free the stage unwritten.
                    completing = 1'b1;
                    err_next   = 1'b1;
                end else begin
                    wait_cnt_next = wait_cnt_reg + 16'd1;
                end
            end
            default: ;
        endcase

        in_ready = (state_reg == ST_EMPTY) || completing;
        accept   = in_valid && in_ready;

        if (retiring) begin
            retire_cnt_next = retire_cnt_reg + 16'd1;
        end

        if (accept) begin
            op_next   = in_op_dec;
            rd_next   = in_rd;
            data_next = merged_data;
            if (in_op_dec == WB_LOAD) begin
                state_next    = ST_WAIT;
                wait_cnt_next = '0;
            end else begin
                state_next = ST_FULL;
            end
        end else if (completing) begin
            state_next = ST_EMPTY;
        end
    end

    // A reset cycle must never write, even if load data arrives in it.
    assign rf_wen = wen_raw && !rst;

    for (genvar gi = 0; gi < DSIZE; gi++) begin : g_wdata_gate
        assign rf_wdata[gi] = wdata_raw[gi] & rf_wen;
    end

    for (genvar gi = 0; gi < RSIZE; gi++) begin : g_waddr_gate
        assign rf_waddr[gi] = rd_reg[gi] & rf_wen;
    end

    assign busy       = (state_reg != ST_EMPTY);
    assign retire_cnt = retire_cnt_reg;
    assign err        = err_reg;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: expected register-file writes are queued when
// stimulus is driven and popped whenever the DUT asserts rf_wen.
module tb_wb_stage;

    typedef struct {
        logic [3:0]  rd;
        logic [15:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [3:0]  in_rd;
    logic [15:0] in_alu;
    logic [7:0]  in_imm;
    logic [15:0] in_old;
    logic [15:0] in_pc1;
    logic        mem_rvalid;
    logic [15:0] mem_rdata;
    logic        rf_wen;
    logic [3:0]  rf_waddr;
    logic [15:0] rf_wdata;
    logic        busy;
    logic [15:0] retire_cnt;
    logic        err;

    int checks   = 0;
    int failures = 0;
    wr_t exp_q[$];

    always #5 clk = ~clk;

    wb_stage #(
        .DSIZE(16),
        .RSIZE(4),
        .TIMEOUT(4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_rd      (in_rd),
        .in_alu     (in_alu),
        .in_imm     (in_imm),
        .in_old     (in_old),
        .in_pc1     (in_pc1),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .rf_wen     (rf_wen),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .busy       (busy),
        .retire_cnt (retire_cnt),
        .err        (err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic settle();
        #1;
    endtask

    // Scoreboard monitor for the current cycle, then advance one clock.
    task automatic tick();
        wr_t e;
        if (rf_wen === 1'b1) begin
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("wr_addr", 32'(rf_waddr), 32'(e.rd));
                chk("wr_data", 32'(rf_wdata), 32'(e.data));
                $display("write rd=%0d data=0x%04h", rf_waddr, rf_wdata);
            end else begin
                chk("spurious_wen", 32'(rf_wen), 32'd0);
            end
        end else begin
            chk("idle_waddr", 32'(rf_waddr), 32'd0);
            chk("idle_wdata", 32'(rf_wdata), 32'd0);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] op, input logic [3:0] rd, input logic [15:0] alu,
                         input logic [7:0] imm, input logic [15:0] old, input logic [15:0] pc1);
        in_valid = 1'b1;
        in_op    = op;
        in_rd    = rd;
        in_alu   = alu;
        in_imm   = imm;
        in_old   = old;
        in_pc1   = pc1;
    endtask

    task automatic push(input logic [3:0] rd, input logic [15:0] data);
        wr_t e;
        e.rd   = rd;
        e.data = data;
        exp_q.push_back(e);
    endtask

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_op      = 3'd0;
        in_rd      = 4'd0;
        in_alu     = 16'd0;
        in_imm     = 8'd0;
        in_old     = 16'd0;
        in_pc1     = 16'd0;
        mem_rvalid = 1'b0;
        mem_rdata  = 16'd0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        settle();
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_rf_wen", 32'(rf_wen), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_retire_cnt", 32'(retire_cnt), 32'd0);
        chk("rst_err", 32'(err), 32'd0);

        // ALU rd=3
        drive(3'd1, 4'd3, 16'h1234, 8'h00, 16'h0000, 16'h0000);
        push(4'd3, 16'h1234);
        settle();
        chk("alu_in_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        settle();
        chk("alu_wen", 32'(rf_wen), 32'd1);
        tick();
        chk("alu_retire_cnt", 32'(retire_cnt), 32'd1);
        $display("alu done retire_cnt=%0d", retire_cnt);

        // LHB then LLB back-to-back
        drive(3'd3, 4'd5, 16'h0000, 8'h12, 16'hABCD, 16'h0000);
        push(4'd5, 16'h12CD);
        settle();
        chk("lhb_in_ready", 32'(in_ready), 32'd1);
        tick();
        drive(3'd4, 4'd5, 16'h0000, 8'h12, 16'hABCD, 16'h0000);
        push(4'd5, 16'hAB12);
        settle();
        chk("llb_in_ready", 32'(in_ready), 32'd1);
        chk("lhb_wen", 32'(rf_wen), 32'd1);
        tick();
        in_valid = 1'b0;
        settle();
        chk("llb_wen", 32'(rf_wen), 32'd1);
        tick();
        chk("lhb_llb_retire_cnt", 32'(retire_cnt), 32'd3);

        // LOAD rd=7 with data on the third WAIT cycle
        drive(3'd2, 4'd7, 16'h0000, 8'h00, 16'h0000, 16'h0000);
        settle();
        tick();
        in_valid = 1'b0;
        settle();
        chk("load_wait1_ready", 32'(in_ready), 32'd0);
        chk("load_wait1_busy", 32'(busy), 32'd1);
        tick();
        chk("load_wait2_ready", 32'(in_ready), 32'd0);
        tick();
        mem_rvalid = 1'b1;
        mem_rdata  = 16'hBEEF;
        push(4'd7, 16'hBEEF);
        settle();
        chk("load_done_ready", 32'(in_ready), 32'd1);
        chk("load_done_wen", 32'(rf_wen), 32'd1);
        tick();
        mem_rvalid = 1'b0;
        settle();
        chk("load_after_busy", 32'(busy), 32'd0);
        chk("load_retire_cnt", 32'(retire_cnt), 32'd4);

        // LOAD timeout (TIMEOUT=4)
        drive(3'd2, 4'd9, 16'h0000, 8'h00, 16'h0000, 16'h0000);
        settle();
        tick();
        in_valid = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            settle();
            chk("to_in_ready", 32'(in_ready), (i == 4) ? 32'd1 : 32'd0);
            chk("to_err_low", 32'(err), 32'd0);
            tick();
        end
        chk("to_err_set", 32'(err), 32'd1);
        chk("to_busy", 32'(busy), 32'd0);
        chk("to_retire_cnt", 32'(retire_cnt), 32'd4);
        tick();
        tick();
        chk("to_err_sticky", 32'(err), 32'd1);
        $display("timeout err=%0d retire_cnt=%0d", err, retire_cnt);

        // JAL rd=0: no write, still retires
        drive(3'd5, 4'd0, 16'h0000, 8'h00, 16'h0000, 16'h0042);
        settle();
        tick();
        in_valid = 1'b0;
        settle();
        chk("jal_r0_wen", 32'(rf_wen), 32'd0);
        tick();
        chk("jal_r0_retire_cnt", 32'(retire_cnt), 32'd5);

        // Reserved op 7 behaves as NONE
        drive(3'd7, 4'd4, 16'hFFFF, 8'hFF, 16'hFFFF, 16'hFFFF);
        settle();
        tick();
        in_valid = 1'b0;
        settle();
        chk("op7_wen", 32'(rf_wen), 32'd0);
        tick();
        chk("op7_retire_cnt", 32'(retire_cnt), 32'd6);

        // mem_rvalid while EMPTY is ignored
        mem_rvalid = 1'b1;
        mem_rdata  = 16'h5555;
        settle();
        chk("idle_rvalid_wen", 32'(rf_wen), 32'd0);
        tick();
        mem_rvalid = 1'b0;
        chk("idle_rvalid_busy", 32'(busy), 32'd0);

        // Reset while in WAIT with data arriving
        drive(3'd2, 4'd2, 16'h0000, 8'h00, 16'h0000, 16'h0000);
        settle();
        tick();
        in_valid = 1'b0;
        tick();
        rst        = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 16'h1111;
        settle();
        chk("rst_wait_wen", 32'(rf_wen), 32'd0);
        tick();
        rst        = 1'b0;
        mem_rvalid = 1'b0;
        settle();
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        chk("post_rst_wen", 32'(rf_wen), 32'd0);
        chk("post_rst_busy", 32'(busy), 32'd0);
        chk("post_rst_retire_cnt", 32'(retire_cnt), 32'd0);
        chk("post_rst_err", 32'(err), 32'd0);
        mem_rvalid = 1'b1;
        settle();
        tick();
        mem_rvalid = 1'b0;
        settle();
        chk("post_rst_busy2", 32'(busy), 32'd0);

        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
